// File: rtl/agc_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : agc_sched_pkg
// Description : Shared types and constants for the AGC divider scheduler.
// Revision    : 1.0
// ============================================================================
package agc_sched_pkg;

    localparam int MAX_CH    = 8;
    localparam int TAG_CH_W  = $clog2(MAX_CH);
    localparam int DVD_W_DEF = 16;
    localparam int DVS_W_DEF = 8;

    // Quotient field position inside the divider result word.
    localparam int QUO_LSB = DVS_W_DEF;
    localparam int QUO_MSB = DVD_W_DEF + DVS_W_DEF - 1;

    typedef struct packed {
        logic                v;
        logic [TAG_CH_W-1:0] ch;
        logic                dz;
    } tag_t;

    localparam tag_t TAG_IDLE = '{v: 1'b0, ch: '0, dz: 1'b0};

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin one-hot grant; search starts one past i_last.
// Revision    : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_last,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_grant_idx
);

    int w_idx;

    // Walk from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_idx       = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(i_last) + k) % N;
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = PW'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/agc_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : agc_div_scheduler
// Description : Shares one pipelined divider between AGC channels with tag steering.
// Revision    : 1.0
// ============================================================================
module agc_div_scheduler
    import agc_sched_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DIV_LATENCY = 20,
    parameter int DVD_W       = DVD_W_DEF,
    parameter int DVS_W       = DVS_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [N_CH-1:0]         req_valid,
    output logic [N_CH-1:0]         req_ready,
    input  logic [N_CH*DVD_W-1:0]   req_dividend,
    input  logic [N_CH*DVS_W-1:0]   req_divisor,
    output logic                    div_s_tvalid,
    output logic [DVD_W-1:0]        div_dividend,
    output logic [DVS_W-1:0]        div_divisor,
    input  logic                    div_m_tvalid,
    input  logic [DVD_W+DVS_W-1:0]  div_m_tdata,
    output logic [N_CH-1:0]         res_valid,
    output logic [DVD_W-1:0]        res_quotient,
    output logic                    res_dz,
    output logic                    busy,
    output logic                    err_sync
);

    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]  w_req;
    logic [N_CH-1:0]  w_grant;
    logic [CH_W-1:0]  w_grant_idx;
    logic             w_accept;
    logic [DVD_W-1:0] w_sel_dividend;
    logic [DVS_W-1:0] w_sel_divisor;
    logic             w_sel_dz;
    logic [DVD_W-1:0] w_quotient;
    logic             w_unused_rem;
    tag_t             w_head;
    logic             w_busy;

    logic [CH_W-1:0]  rr_last_q,      rr_last_d;
    logic             div_s_tvalid_q, div_s_tvalid_d;
    logic [DVD_W-1:0] div_dividend_q, div_dividend_d;
    logic [DVS_W-1:0] div_divisor_q,  div_divisor_d;
    logic [N_CH-1:0]  res_valid_q,    res_valid_d;
    logic [DVD_W-1:0] res_quotient_q, res_quotient_d;
    logic             res_dz_q,       res_dz_d;
    logic             err_sync_q,     err_sync_d;

    // Stage 0 travels alongside div_s_tvalid; stage DIV_LATENCY meets the divider output.
    tag_t tags_q [0:DIV_LATENCY];
    tag_t tags_d [0:DIV_LATENCY];

    assign w_req = req_valid & {N_CH{enable & reset_n}};

    rr_arbiter #(
        .N  (N_CH),
        .PW (CH_W)
    ) u_arb (
        .i_req       (w_req),
        .i_last      (rr_last_q),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_accept       = |w_grant;
    assign w_sel_dividend = req_dividend[int'(w_grant_idx)*DVD_W +: DVD_W];
    assign w_sel_divisor  = req_divisor[int'(w_grant_idx)*DVS_W +: DVS_W];
    assign w_sel_dz       = (w_sel_divisor == '0);
    assign w_quotient     = div_m_tdata[DVD_W+DVS_W-1 -: DVD_W];
    assign w_unused_rem   = ^div_m_tdata[DVS_W-1:0];
    assign w_head         = tags_q[DIV_LATENCY];

    always_comb begin
        rr_last_d      = w_accept ? w_grant_idx : rr_last_q;
        div_s_tvalid_d = w_accept & ~w_sel_dz;
        div_dividend_d = div_s_tvalid_d ? w_sel_dividend : div_dividend_q;
        div_divisor_d  = div_s_tvalid_d ? w_sel_divisor  : div_divisor_q;

        tags_d[0] = TAG_IDLE;
        if (w_accept) begin
            tags_d[0] = '{v: 1'b1, ch: TAG_CH_W'(w_grant_idx), dz: w_sel_dz};
        end
        for (int k = 1; k <= DIV_LATENCY; k++) begin
            tags_d[k] = tags_q[k-1];
        end

        res_valid_d    = '0;
        res_quotient_d = res_quotient_q;
        res_dz_d       = res_dz_q;
        err_sync_d     = err_sync_q;
        if (w_head.v) begin
            if (w_head.dz || div_m_tvalid) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (w_head.ch == TAG_CH_W'(i)) begin
                        res_valid_d[i] = 1'b1;
                    end
                end
                res_quotient_d = w_head.dz ? '1 : w_quotient;
                res_dz_d       = w_head.dz;
            end
            if (w_head.dz == div_m_tvalid) begin
                err_sync_d = 1'b1;
            end
        end else if (div_m_tvalid) begin
            err_sync_d = 1'b1;
        end
    end

    always_comb begin
        w_busy = div_s_tvalid_q;
        for (int k = 0; k <= DIV_LATENCY; k++) begin
            w_busy = w_busy | tags_q[k].v;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_last_q      <= CH_W'(N_CH - 1);
            div_s_tvalid_q <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            res_valid_q    <= '0;
            res_quotient_q <= '0;
            res_dz_q       <= 1'b0;
            err_sync_q     <= 1'b0;
            for (int k = 0; k <= DIV_LATENCY; k++) begin
                tags_q[k] <= TAG_IDLE;
            end
        end else begin
            rr_last_q      <= rr_last_d;
            div_s_tvalid_q <= div_s_tvalid_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            res_valid_q    <= res_valid_d;
            res_quotient_q <= res_quotient_d;
            res_dz_q       <= res_dz_d;
            err_sync_q     <= err_sync_d;
            for (int k = 0; k <= DIV_LATENCY; k++) begin
                tags_q[k] <= tags_d[k];
            end
        end
    end

    assign req_ready    = w_grant;
    assign div_s_tvalid = div_s_tvalid_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;
    assign res_valid    = res_valid_q;
    assign res_quotient = res_quotient_q;
    assign res_dz       = res_dz_q;
    assign busy         = w_busy;
    assign err_sync     = err_sync_q;

endmodule
`default_nettype wire

// File: tb/tb_agc_div_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_agc_div_scheduler
// Description : Self-checking bench with divider model and result scoreboard.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_agc_div_scheduler;
    import agc_sched_pkg::*;

    localparam int N  = 4;
    localparam int L  = 20;
    localparam int DW = 16;
    localparam int SW = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            enable = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_dividend = '0;
    logic [N*SW-1:0] req_divisor = '0;
    logic [N-1:0]    req_ready;
    logic            div_s_tvalid;
    logic [DW-1:0]   div_dividend;
    logic [SW-1:0]   div_divisor;
    logic            div_m_tvalid;
    logic [DW+SW-1:0] div_m_tdata;
    logic [N-1:0]    res_valid;
    logic [DW-1:0]   res_quotient;
    logic            res_dz;
    logic            busy;
    logic            err_sync;

    int checks = 0;
    int errors = 0;
    longint cyc = 0;

    agc_div_scheduler #(
        .N_CH(N), .DIV_LATENCY(L), .DVD_W(DW), .DVS_W(SW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_s_tvalid(div_s_tvalid), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_m_tvalid(div_m_tvalid), .div_m_tdata(div_m_tdata),
        .res_valid(res_valid), .res_quotient(res_quotient), .res_dz(res_dz),
        .busy(busy), .err_sync(err_sync)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- divider model: fixed latency L, held in reset with the DUT
    logic inject = 1'b0;
    logic             dv_pipe [L];
    logic [DW+SW-1:0] dd_pipe [L];

    function automatic logic [DW+SW-1:0] div_fn(input logic [DW-1:0] a, input logic [SW-1:0] b);
        logic [DW+SW-1:0] r;
        r = '0;
        if (b != 0) begin
            r[QUO_MSB:QUO_LSB] = a / {8'd0, b};
            r[QUO_LSB-1:0]     = SW'(a % {8'd0, b});
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < L; i++) dv_pipe[i] <= 1'b0;
        end else begin
            dv_pipe[0] <= div_s_tvalid;
            dd_pipe[0] <= div_fn(div_dividend, div_divisor);
            for (int i = 1; i < L; i++) begin
                dv_pipe[i] <= dv_pipe[i-1];
                dd_pipe[i] <= dd_pipe[i-1];
            end
        end
    end
    assign div_m_tvalid = dv_pipe[L-1] | inject;
    assign div_m_tdata  = dd_pipe[L-1];

    // ---------------- reference model: rr pointer + in-order result scoreboard
    typedef struct {
        int          ch;
        logic [15:0] q;
        logic        dz;
        longint      due;
    } exp_t;
    exp_t        expq[$];
    exp_t        m_e;
    int          model_last = N - 1;
    logic        model_err = 1'b0;
    logic        exp_divs_v = 1'b0;
    logic [15:0] exp_divs_dd;
    logic [7:0]  exp_divs_ds;
    logic [N-1:0] m_exp_res, m_req, m_exp_grant;
    int          m_gidx, m_idx;
    logic        m_head_v, m_head_dz;
    logic [15:0] m_dd;
    logic [7:0]  m_ds;

    always @(negedge clk) begin
        if (!reset_n) begin
            expq.delete();
            model_last = N - 1;
            model_err  = 1'b0;
            exp_divs_v = 1'b0;
        end else begin
            m_exp_res = '0;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                m_e = expq.pop_front();
                m_exp_res[m_e.ch] = 1'b1;
                chk("res_quotient", 32'(res_quotient), 32'(m_e.q));
                chk("res_dz", 32'(res_dz), 32'(m_e.dz));
            end
            chk("res_valid", 32'(res_valid), 32'(m_exp_res));
            chk("busy", 32'(busy), 32'(expq.size() > 0));
            chk("err_sync", 32'(err_sync), 32'(model_err));
            chk("div_s_tvalid", 32'(div_s_tvalid), 32'(exp_divs_v));
            if (exp_divs_v) begin
                chk("div_dividend", 32'(div_dividend), 32'(exp_divs_dd));
                chk("div_divisor", 32'(div_divisor), 32'(exp_divs_ds));
            end
            m_head_v  = expq.size() > 0 && expq[0].due == cyc + 1;
            m_head_dz = m_head_v && expq[0].dz;
            if ((div_m_tvalid && !(m_head_v && !m_head_dz)) ||
                (m_head_v && !m_head_dz && !div_m_tvalid))
                model_err = 1'b1;

            m_req = req_valid & {N{enable}};
            m_gidx = -1;
            for (int k = 1; k <= N; k++) begin
                m_idx = (model_last + k) % N;
                if (m_gidx < 0 && m_req[m_idx]) m_gidx = m_idx;
            end
            m_exp_grant = '0;
            if (m_gidx >= 0) m_exp_grant[m_gidx] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(m_exp_grant));
            exp_divs_v = 1'b0;
            if (m_gidx >= 0) begin
                m_dd = req_dividend[m_gidx*DW +: DW];
                m_ds = req_divisor[m_gidx*SW +: SW];
                model_last = m_gidx;
                m_e.ch  = m_gidx;
                m_e.dz  = (m_ds == 0);
                m_e.q   = (m_ds == 0) ? 16'hFFFF : m_dd / {8'd0, m_ds};
                m_e.due = cyc + L + 2;
                expq.push_back(m_e);
                exp_divs_v  = (m_ds != 0);
                exp_divs_dd = m_dd;
                exp_divs_ds = m_ds;
            end
        end
    end

    // ---------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = '0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic set_ch(input int ch, input logic [15:0] dd, input logic [7:0] ds);
        req_dividend[ch*DW +: DW] = dd;
        req_divisor[ch*SW +: SW]  = ds;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    typedef struct {
        int          ch;
        logic [15:0] dd;
        logic [7:0]  ds;
        logic [15:0] q;
        logic        dz;
    } vec_t;
    vec_t vecs[6];

    int  order[$];
    int  divs_cnt, res_cnt, acc_cnt, lat;
    longint t0;
    logic [N-1:0] acc;

    initial begin
        vecs[0] = '{ch: 2, dd: 16'd8100,  ds: 8'd100, q: 16'd81,    dz: 1'b0};
        vecs[1] = '{ch: 1, dd: 16'd500,   ds: 8'd0,   q: 16'hFFFF,  dz: 1'b1};
        vecs[2] = '{ch: 0, dd: 16'd65535, ds: 8'd255, q: 16'd257,   dz: 1'b0};
        vecs[3] = '{ch: 3, dd: 16'd100,   ds: 8'd7,   q: 16'd14,    dz: 1'b0};
        vecs[4] = '{ch: 2, dd: 16'd7,     ds: 8'd9,   q: 16'd0,     dz: 1'b0};
        vecs[5] = '{ch: 3, dd: 16'd65535, ds: 8'd1,   q: 16'd65535, dz: 1'b0};

        // reset state
        repeat (3) tick();
        req_valid = '1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_div_s_tvalid", 32'(div_s_tvalid), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_quotient", 32'(res_quotient), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err_sync", 32'(err_sync), 0);
        do_reset();

        // single-request table
        enable = 1'b1;
        for (int v = 0; v < 6; v++) begin
            req_valid = '0;
            set_ch(vecs[v].ch, vecs[v].dd, vecs[v].ds);
            req_valid[vecs[v].ch] = 1'b1;
            @(negedge clk);
            t0 = cyc;
            chk("tbl_ready", 32'(req_ready), 32'(1 << vecs[v].ch));
            tick();
            req_valid = '0;
            @(negedge clk);
            chk("tbl_div_s", 32'(div_s_tvalid), 32'(vecs[v].ds != 0));
            while (!res_valid[vecs[v].ch] && cyc < t0 + L + 10) @(negedge clk);
            lat = int'(cyc - t0);
            chk("tbl_res_valid", 32'(res_valid), 32'(1 << vecs[v].ch));
            chk("tbl_latency", 32'(lat), L + 2);
            chk("tbl_quotient", 32'(res_quotient), 32'(vecs[v].q));
            chk("tbl_dz", 32'(res_dz), 32'(vecs[v].dz));
            tick();
        end

        // full load: strict rotation from channel 0
        do_reset();
        for (int i = 0; i < N; i++) set_ch(i, 16'(1000 + 37 * i), 8'(3 + i));
        req_valid = '1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("load_grant", 32'(onehot_idx(req_ready)), 32'(k % N));
            tick();
        end
        req_valid = '0;
        repeat (L + 4) tick();
        chk("load_err_sync", 32'(err_sync), 0);

        // zero divisor between normal requests; results stay in order
        do_reset();
        set_ch(0, 16'd1000, 8'd10);
        set_ch(1, 16'd500, 8'd0);
        set_ch(3, 16'd900, 8'd30);
        req_valid = 4'b1011;
        order.delete();
        divs_cnt = 0;
        for (int k = 0; k < L + 8; k++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (div_s_tvalid) divs_cnt++;
            if (res_valid != 0) order.push_back(onehot_idx(res_valid));
            tick();
            req_valid = req_valid & ~acc;
        end
        chk("dz_divs_count", 32'(divs_cnt), 2);
        chk("dz_res_count", 32'(order.size()), 3);
        if (order.size() == 3) begin
            chk("dz_order0", 32'(order[0]), 0);
            chk("dz_order1", 32'(order[1]), 1);
            chk("dz_order2", 32'(order[2]), 3);
        end

        // enable drop after three accepts; in-flight work drains
        do_reset();
        req_valid = '1;
        acc_cnt = 0;
        res_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (req_ready != 0) acc_cnt++;
            tick();
        end
        enable = 1'b0;
        for (int k = 0; k < L + 6; k++) begin
            @(negedge clk);
            chk("en_req_ready", 32'(req_ready), 0);
            if (res_valid != 0) res_cnt++;
            tick();
        end
        chk("en_accepts", 32'(acc_cnt), 3);
        chk("en_results", 32'(res_cnt), 3);
        chk("en_busy_idle", 32'(busy), 0);

        // stray divider output
        req_valid = '0;
        enable = 1'b1;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("sync_err", 32'(err_sync), 1);
            chk("sync_no_res", 32'(res_valid), 0);
            tick();
        end

        // reset with five operations in flight
        do_reset();
        req_valid = '1;
        repeat (5) tick();
        req_valid = '0;
        repeat (3) tick();
        reset_n = 1'b0;
        req_valid = '1;
        tick();
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 0);
        chk("mid_rst_div_s", 32'(div_s_tvalid), 0);
        chk("mid_rst_div_dd", 32'(div_dividend), 0);
        chk("mid_rst_div_ds", 32'(div_divisor), 0);
        chk("mid_rst_res_valid", 32'(res_valid), 0);
        chk("mid_rst_res_q", 32'(res_quotient), 0);
        chk("mid_rst_res_dz", 32'(res_dz), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_err", 32'(err_sync), 0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_rr_ch0", 32'(req_ready), 1);
        tick();
        req_valid = '0;
        repeat (L + 4) tick();

        // randomized traffic against the scoreboard
        do_reset();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            enable = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_ch(i, 16'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
                end
            end
        end
        req_valid = '0;
        repeat (L + 5) tick();
        @(negedge clk);
        chk("rand_drain_busy", 32'(busy), 0);
        chk("rand_err_sync", 32'(err_sync), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/agc_div_scheduler.md
# agc_div_scheduler

Shares one pipelined divider (16-bit dividend / 8-bit divisor, fixed latency, no backpressure) between N_CH hydrophone AGC channels. Each channel presents a gain-normalisation request (TARGET-scaled sample over windowed RMS). The scheduler round-robins requests into the divider and carries channel tags through a latency-matched pipeline. It steers each quotient back to its channel. Divide-by-zero requests are handled locally with in-order saturation. The block sits between the per-channel RMS/multiply stages and the divider instance in the acoustics front end.

## Interface
Parameters:
- N_CH, 4, number of requesting channels (2..8)
- DIV_LATENCY, 20, divider input-valid to output-valid latency in cycles (≥2)
- DVD_W, 16, dividend width
- DVS_W, 8, divisor width

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  when low, no new grants; in-flight operations drain normally
- req_valid  in  N_CH  per-channel request valid
- req_ready  out  N_CH  per-channel accept, one-hot or zero
- req_dividend  in  N_CH*DVD_W  channel i at bits [i*DVD_W +: DVD_W]
- req_divisor  in  N_CH*DVS_W  channel i at bits [i*DVS_W +: DVS_W]
- div_s_tvalid  out  1  divider dividend/divisor valid (both driven together)
- div_dividend  out  DVD_W  divider dividend
- div_divisor  out  DVS_W  divider divisor
- div_m_tvalid  in  1  divider result valid
- div_m_tdata  in  DVD_W+DVS_W  quotient in [DVD_W+DVS_W-1:DVS_W], remainder below
- res_valid  out  N_CH  one-cycle pulse on the owning channel
- res_quotient  out  DVD_W  quotient, shared by all channels
- res_dz  out  1  result came from a zero divisor
- busy  out  1  any operation in flight
- err_sync  out  1  sticky; divider output disagreed with tag pipeline

## Operation
- Arbitration is combinational over req_valid & enable. Round-robin pointer rr_last; search starts at rr_last+1 mod N_CH. At most one req_ready bit is high.
- Accept means req_valid[i] & req_ready[i]. On accept, rr_last <= i. Requesters hold data while valid and not ready.
- Accept with divisor ≠ 0: the next edge registers div_dividend/div_divisor and asserts div_s_tvalid for exactly one cycle.
- Accept with divisor = 0: the divider is not driven; div_s_tvalid stays low that cycle.
- Tag pipeline: DIV_LATENCY-deep shift register of {v, ch, dz}. It advances every cycle. On accept it is loaded with {1, i, divisor==0}, aligned with div_s_tvalid. Otherwise it is loaded with 0.
- At the tag pipeline head:
  - v & !dz & div_m_tvalid: register res_valid[ch]=1, res_quotient=quotient field, res_dz=0.
  - v & dz: register res_valid[ch]=1, res_quotient='1 (all ones), res_dz=1. If div_m_tvalid is also high, set err_sync.
  - v & !dz & !div_m_tvalid: no result is emitted; set err_sync.
  - !v & div_m_tvalid: result is dropped; set err_sync.
- Results are never backpressured. Consumers must sample on the res_valid pulse.
- busy = OR of all tag v bits, or any div_s_tvalid pending.
- enable deasserted mid-stream: no new accepts; all accepted operations complete and return.

## Timing
- Request accepted in cycle t; div_s_tvalid is high in cycle t+1.
- Divider result is expected in cycle t+1+DIV_LATENCY. res_valid is high in cycle t+2+DIV_LATENCY.
- Zero-divisor results use the same latency, so results leave in acceptance order.
- Throughput: one accept per cycle sustained. Under full load with all channels requesting, each channel is granted once every N_CH cycles.
- Reset values: req_ready=0, div_s_tvalid=0, div_dividend=0, div_divisor=0, res_valid=0, res_quotient=0, res_dz=0, busy=0, err_sync=0, all tag v=0, rr_last=N_CH-1 (channel 0 wins first).
- Reset mid-operation clears all tags. Divider outputs arriving after reset with no tag set err_sync. Software clears err_sync only by reset; integration holds the divider in reset (aresetn) alongside this block.

## Structure
- Package agc_sched_pkg holds:
  - tag_t struct {logic v; logic [$clog2(N_CH)-1:0] ch; logic dz;}
  - DVD_W/DVS_W defaults
  - the quotient-field slice localparams
- Sub-module rr_arbiter #(N) provides the request-vector/pointer to one-hot grant logic, reusable for other shared front-end resources.
- The divider IP is instantiated outside this block, at the AGC top.

## Test plan
- Single request: ch2 issues 16'd8100 / 8'd100, DIV_LATENCY=20, divider model used -> div_s_tvalid 1 cycle after accept; res_valid[2] 22 cycles after accept; quotient 81; res_dz=0.
- Full load: all 4 channels hold valid for 16 cycles -> grants in order 0,1,2,3,0,… (4 each); each result is routed to the correct channel; back-to-back res_valid pulses; no err_sync.
- Divide-by-zero: ch1 requests 16'd500/0 between ch0 and ch3 normal requests -> div_s_tvalid skipped for ch1; ch1 gets quotient 16'hFFFF with res_dz=1; results arrive in order 0,1,3.
- enable drop: enable=0 after 3 accepts -> req_ready stays 0; 3 results still return; busy falls 1 cycle after the last tag leaves the pipeline head.
- Sync error: inject an extra div_m_tvalid with no pending tag -> err_sync=1 and stays set; no res_valid pulse.
- Reset mid-flight: assert reset_n=0 with 5 operations in flight -> all outputs reach reset values the next cycle; rr restarts at ch0.
